// File: rtl/led7_scan_ctrl_pkg.sv
// Shared types and helpers for the multiplexed 7-segment scan controller.
//   bcd_digit_t  : one BCD nibble (0..9)
//   scan_state_e : converter FSM states
//   bcd_max(n)   : largest value representable in n decimal digits (10**n - 1)
package led7_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        COMMIT
    } scan_state_e;

    function automatic int unsigned bcd_max(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r - 1;
    endfunction

endpackage

// File: rtl/led7_scan_ctrl_if.sv
// Ready/valid load channel into the scan controller.
//   load  : valid, bin is presented for display
//   bin   : unsigned binary value (BIN_W bits)
//   ready : converter idle; a transfer happens when load && ready
// master = value producer, slave = led7_scan_ctrl.
interface led7_scan_ctrl_if #(
    parameter int BIN_W = 14
);
    logic             load;
    logic [BIN_W-1:0] bin;
    logic             ready;

    modport master (output load, output bin, input ready);
    modport slave  (input load, input bin, output ready);
endinterface

// File: rtl/led7_scan_ctrl_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per cycle).
//   clk, rst : clock, asynchronous active-high reset
//   start    : accept bin (only honoured while idle)
//   bin      : unsigned binary input
//   busy     : conversion in progress (CONV or COMMIT)
//   done     : one-cycle strobe while bcd holds the finished result
//   bcd      : 4*N_DIGITS-bit result, all 9s when the input exceeded the display range
module bin2bcd_seq
    import led7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*N_DIGITS-1:0] bcd
);

    localparam int SR_W  = BIN_W + 4*N_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [BIN_W:0]        SAT_LIM = (BIN_W+1)'(bcd_max(N_DIGITS));
    localparam logic [4*N_DIGITS-1:0] ALL_9S  = {N_DIGITS{4'h9}};

    scan_state_e      state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;
    logic [SR_W-1:0]  sr_adj;

    // State register plus datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // Add-3 correction on every BCD nibble >= 5, ahead of the shift.
    always_comb begin
        sr_adj = sr_q;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (sr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    sr_d    = {{(4*N_DIGITS){1'b0}}, bin};
                    cnt_d   = '0;
                    sat_d   = ({1'b0, bin} > SAT_LIM);
                end
            end
            CONV: begin
                sr_d  = {sr_adj[SR_W-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == COMMIT);
        bcd  = sat_q ? ALL_9S : sr_q[SR_W-1 -: 4*N_DIGITS];
    end

endmodule

// File: rtl/led7_scan_ctrl.sv
// Multiplexed N-digit 7-segment scan controller.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : load/bin/ready channel (slave side)
//   num      : BCD nibble of the scanned digit, feeds the segment decoder
//   dig_sel  : one-hot active-high digit enable, all-zero for a blanked digit
// A value accepted on bus is converted to BCD and committed atomically to the
// display register; scanning runs independently and always shows a whole value.
module led7_scan_ctrl
    import led7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int BIN_W       = 14,
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LEAD  = 1
) (
    input  logic                clk,
    input  logic                rst,
    led7_scan_ctrl_if.slave     bus,
    output logic [3:0]          num,
    output logic [N_DIGITS-1:0] dig_sel
);

    localparam int PS_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [N_DIGITS-1:0] SEL0 = N_DIGITS'(1);

    logic                  conv_busy;
    logic                  conv_done;
    logic [4*N_DIGITS-1:0] conv_bcd;

    logic [4*N_DIGITS-1:0] disp_q, disp_d;
    logic [PS_W-1:0]       ps_q, ps_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    bcd_digit_t            num_q, num_d;
    logic [N_DIGITS-1:0]   dig_sel_q, dig_sel_d;
    logic [N_DIGITS-1:0]   lead_zero;
    logic                  upper_zero;
    logic                  blank;

    bin2bcd_seq #(
        .N_DIGITS (N_DIGITS),
        .BIN_W    (BIN_W)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (bus.load),
        .bin   (bus.bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_comb begin
        bus.ready = !conv_busy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q    <= '0;
            ps_q      <= '0;
            idx_q     <= '0;
            num_q     <= '0;
            dig_sel_q <= SEL0;
        end else begin
            disp_q    <= disp_d;
            ps_q      <= ps_d;
            idx_q     <= idx_d;
            num_q     <= num_d;
            dig_sel_q <= dig_sel_d;
        end
    end

    always_comb begin
        disp_d = conv_done ? conv_bcd : disp_q;

        if (ps_q == PS_W'(REFRESH_DIV - 1)) begin
            ps_d  = '0;
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            ps_d  = ps_q + 1'b1;
            idx_d = idx_q;
        end

        // lead_zero[i]: digit i and every digit above it are zero.
        upper_zero = 1'b1;
        lead_zero  = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            upper_zero = upper_zero && (disp_d[4*(N_DIGITS-1-k) +: 4] == 4'd0);
            lead_zero[N_DIGITS-1-k] = upper_zero;
        end
        blank = (BLANK_LEAD != 0) && (idx_d != '0) && lead_zero[idx_d];

        // Outputs track the next index and next display contents so they move
        // on the same edge as idx and as the commit.
        num_d     = disp_d[4*idx_d +: 4];
        dig_sel_d = '0;
        if (!blank) begin
            dig_sel_d[idx_d] = 1'b1;
        end
    end

    always_comb begin
        num     = num_q;
        dig_sel = dig_sel_q;
    end

endmodule

// File: tb/tb_led7_scan_ctrl.sv
// Directed plus random bench for led7_scan_ctrl (4 digits, 14-bit input,
// 4-cycle slots, leading-zero blanking). Expected outputs come from a
// decimal model: displayed integer, slot index from cycles since reset,
// and commit scheduled a fixed number of edges after acceptance.
module tb_led7_scan_ctrl;
    import led7_pkg::*;

    localparam int ND = 4;
    localparam int BW = 14;
    localparam int RD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    num;
    logic [ND-1:0] dig_sel;

    led7_scan_ctrl_if #(.BIN_W(BW)) bus ();

    led7_scan_ctrl #(
        .N_DIGITS    (ND),
        .BIN_W       (BW),
        .REFRESH_DIV (RD),
        .BLANK_LEAD  (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .num     (num),
        .dig_sel (dig_sel)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state.
    int cyc;
    int disp;
    int pend;
    int commit_at;
    bit m_ready;

    function automatic int pow10(input int i);
        int r = 1;
        for (int k = 0; k < i; k++) r = r * 10;
        return r;
    endfunction

    function automatic int digit_of(input int v, input int i);
        return (v / pow10(i)) % 10;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        int idx;
        int sel;
        idx = (cyc / RD) % ND;
        sel = (idx == 0 || disp >= pow10(idx)) ? (1 << idx) : 0;
        chk("ready",   int'(bus.ready), int'(m_ready));
        chk("num",     int'(num),       digit_of(disp, idx));
        chk("dig_sel", int'(dig_sel),   sel);
    endtask

    // One clock: drive at negedge, model the edge, check #1 later, return at negedge.
    task automatic step(input bit ld, input int b);
        bus.load = ld;
        bus.bin  = b[BW-1:0];
        @(posedge clk);
        cyc++;
        if (ld && m_ready) begin
            pend      = (b > 9999) ? 9999 : b;
            commit_at = cyc + BW + 1;
            m_ready   = 1'b0;
        end else if (!m_ready && cyc == commit_at) begin
            disp    = pend;
            m_ready = 1'b1;
        end
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, int'($urandom_range(0, 16383)));
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic do_reset();
        bus.load = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_ready",   int'(bus.ready), 1);
        chk("rst_num",     int'(num),       0);
        chk("rst_dig_sel", int'(dig_sel),   1);
        disp      = 0;
        m_ready   = 1'b1;
        cyc       = 0;
        commit_at = -1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit found;
        rst       = 1'b1;
        bus.load  = 1'b0;
        bus.bin   = '0;
        disp      = 0;
        m_ready   = 1'b1;
        cyc       = 0;
        commit_at = -1;
        #1;
        chk("init_ready",   int'(bus.ready), 1);
        chk("init_num",     int'(num),       0);
        chk("init_dig_sel", int'(dig_sel),   1);
        @(negedge clk);
        rst = 1'b0;

        // Idle after reset: only digit 0 lit.
        idle(20);

        // Plain conversion and full scan.
        step(1'b1, 1234);
        idle(34);

        // Small values exercise leading-zero blanking.
        step(1'b1, 7);
        idle(36);
        step(1'b1, 305);
        idle(36);

        // Out-of-range input saturates.
        step(1'b1, 16383);
        idle(36);
        step(1'b1, 10000);
        idle(36);
        step(1'b1, 9999);
        idle(20);
        step(1'b1, 0);
        idle(20);

        // Loads during conversion are ignored.
        step(1'b1, 1234);
        idle(3);
        step(1'b1, 42);
        idle(4);
        step(1'b1, 42);
        idle(30);

        // Back-to-back: load held high re-accepts as soon as ready returns.
        for (int i = 0; i < 40; i++) step(1'b1, 1000 + i);
        idle(20);

        // Reset mid-conversion.
        step(1'b1, 8765);
        idle(6);
        do_reset();
        idle(20);

        // Reset during slot 2 of a displayed value.
        step(1'b1, 1234);
        idle(20);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (((cyc / RD) % ND) == 2 && (cyc % RD) == 1) found = 1'b1;
            else step(1'b0, 0);
        end
        chk("reach_slot2", int'(found), 1);
        do_reset();
        idle(20);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            int b;
            case ($urandom_range(0, 3))
                0:       b = int'($urandom_range(0, 9));
                1:       b = int'($urandom_range(0, 999));
                2:       b = int'($urandom_range(0, 9999));
                default: b = int'($urandom_range(0, 16383));
            endcase
            step($urandom_range(0, 7) == 0, b);
        end
        idle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
